// File: rtl/matrix_store.sv
`default_nettype none
// ============================================================================
// Module      : matrix_store
// Description : Four-slot matrix storage with per-slot dimensions, registered
//               read port and a sequential slot-clear engine.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_store #(
    parameter int MAX_DIM = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  wr_slot,
    input  logic [2:0]  wr_row,
    input  logic [2:0]  wr_col,
    input  logic [15:0] wr_data,
    input  logic        wr_we,
    input  logic [2:0]  dim_m,
    input  logic [2:0]  dim_n,
    input  logic        dim_we,
    input  logic [1:0]  rd_slot,
    input  logic [2:0]  rd_row,
    input  logic [2:0]  rd_col,
    input  logic        rd_en,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        rd_oob,
    output logic [2:0]  rd_dim_m,
    output logic [2:0]  rd_dim_n,
    output logic        rd_slot_valid,
    input  logic        clr_start,
    input  logic [1:0]  clr_slot,
    output logic        clr_busy,
    output logic        clr_done,
    output logic        err,
    input  logic        err_clr
);

    localparam int         c_cells    = MAX_DIM * MAX_DIM;
    localparam int         c_depth    = 4 * c_cells;
    localparam int         c_aw       = $clog2(c_depth);
    localparam logic [2:0] c_dim_max  = 3'(MAX_DIM);
    localparam logic [2:0] c_idx_last = 3'(MAX_DIM - 1);

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_RUN  = 2'd1,
        C_DONE = 2'd2
    } clr_state_e;

    clr_state_e       state_q, state_d;
    logic [1:0]       clr_slot_q, clr_slot_d;
    logic [2:0]       clr_r_q, clr_r_d;
    logic [2:0]       clr_c_q, clr_c_d;
    logic [3:0][2:0]  dim_m_q, dim_m_d;
    logic [3:0][2:0]  dim_n_q, dim_n_d;
    logic [3:0]       valid_q, valid_d;
    logic             err_q, err_d;
    logic [15:0]      rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_oob_q, rd_oob_d;

    logic [15:0]      mem_q [c_depth];
    logic             mem_we;
    logic [c_aw-1:0]  mem_waddr;
    logic [15:0]      mem_wdata;

    logic             idle;
    logic             wr_ok;
    logic             dim_ok;
    logic             rd_ok;
    logic             err_set;
    logic [c_aw-1:0]  wr_addr;
    logic [c_aw-1:0]  rd_addr;
    logic [c_aw-1:0]  clr_addr;

    function automatic logic [c_aw-1:0] cell_addr(input logic [1:0] s,
                                                  input logic [2:0] r,
                                                  input logic [2:0] c);
        return c_aw'(int'(s) * c_cells + int'(r) * MAX_DIM + int'(c));
    endfunction

    // All acceptance checks look at pre-edge register state only.
    assign idle    = (state_q == C_IDLE);
    assign wr_ok   = idle && valid_q[wr_slot] &&
                     (wr_row < dim_m_q[wr_slot]) && (wr_col < dim_n_q[wr_slot]);
    assign dim_ok  = idle && (dim_m != 3'd0) && (dim_m <= c_dim_max) &&
                     (dim_n != 3'd0) && (dim_n <= c_dim_max);
    assign rd_ok   = valid_q[rd_slot] &&
                     (rd_row < dim_m_q[rd_slot]) && (rd_col < dim_n_q[rd_slot]);
    assign err_set = (dim_we && !dim_ok) || (wr_we && !wr_ok);

    assign wr_addr  = cell_addr(wr_slot, wr_row, wr_col);
    assign rd_addr  = cell_addr(rd_slot, rd_row, rd_col);
    assign clr_addr = cell_addr(clr_slot_q, clr_r_q, clr_c_q);

    // Element writes are only accepted in C_IDLE, so the clear engine never
    // competes with them for the single write port.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = 16'h0000;
        if (!rst) begin
            if (state_q == C_RUN) begin
                mem_we    = 1'b1;
                mem_waddr = clr_addr;
            end else if (wr_we && wr_ok) begin
                mem_we    = 1'b1;
                mem_waddr = wr_addr;
                mem_wdata = wr_data;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_slot_d = clr_slot_q;
        clr_r_d    = clr_r_q;
        clr_c_d    = clr_c_q;
        dim_m_d    = dim_m_q;
        dim_n_d    = dim_n_q;
        valid_d    = valid_q;
        err_d      = err_set | (err_q & ~err_clr);
        rd_valid_d = rd_en;
        rd_oob_d   = rd_en & ~rd_ok;
        rd_data_d  = rd_data_q;

        if (rd_en) begin
            if (rd_ok) begin
                rd_data_d = mem_q[rd_addr];
            end else begin
                rd_data_d = 16'h0000;
            end
        end

        if (dim_we && dim_ok) begin
            dim_m_d[wr_slot] = dim_m;
            dim_n_d[wr_slot] = dim_n;
            valid_d[wr_slot] = 1'b1;
        end

        // A clear started in the same cycle as a dim write to that slot wins.
        case (state_q)
            C_IDLE: begin
                if (clr_start) begin
                    clr_slot_d        = clr_slot;
                    dim_m_d[clr_slot] = 3'd0;
                    dim_n_d[clr_slot] = 3'd0;
                    valid_d[clr_slot] = 1'b0;
                    clr_r_d           = 3'd0;
                    clr_c_d           = 3'd0;
                    state_d           = C_RUN;
                end
            end
            C_RUN: begin
                if (clr_c_q == c_idx_last) begin
                    clr_c_d = 3'd0;
                    if (clr_r_q == c_idx_last) begin
                        state_d = C_DONE;
                    end else begin
                        clr_r_d = clr_r_q + 3'd1;
                    end
                end else begin
                    clr_c_d = clr_c_q + 3'd1;
                end
            end
            C_DONE: begin
                state_d = C_IDLE;
            end
            default: begin
                state_d = C_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= C_IDLE;
            clr_slot_q <= 2'd0;
            clr_r_q    <= 3'd0;
            clr_c_q    <= 3'd0;
            dim_m_q    <= '0;
            dim_n_q    <= '0;
            valid_q    <= 4'h0;
            err_q      <= 1'b0;
            rd_data_q  <= 16'h0000;
            rd_valid_q <= 1'b0;
            rd_oob_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_slot_q <= clr_slot_d;
            clr_r_q    <= clr_r_d;
            clr_c_q    <= clr_c_d;
            dim_m_q    <= dim_m_d;
            dim_n_q    <= dim_n_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_oob_q   <= rd_oob_d;
        end
    end

    assign rd_data       = rd_data_q;
    assign rd_valid      = rd_valid_q;
    assign rd_oob        = rd_oob_q;
    assign rd_dim_m      = dim_m_q[rd_slot];
    assign rd_dim_n      = dim_n_q[rd_slot];
    assign rd_slot_valid = valid_q[rd_slot];
    assign clr_busy      = (state_q == C_RUN);
    assign clr_done      = (state_q == C_DONE);
    assign err           = err_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_store.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_store
// Description : Scenario tasks plus a randomized run against a slot/array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_store;
    localparam int MD = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  wr_slot = '0;
    logic [2:0]  wr_row = '0, wr_col = '0;
    logic [15:0] wr_data = '0;
    logic        wr_we = 1'b0;
    logic [2:0]  dim_m = '0, dim_n = '0;
    logic        dim_we = 1'b0;
    logic [1:0]  rd_slot = '0;
    logic [2:0]  rd_row = '0, rd_col = '0;
    logic        rd_en = 1'b0;
    logic [15:0] rd_data;
    logic        rd_valid, rd_oob;
    logic [2:0]  rd_dim_m, rd_dim_n;
    logic        rd_slot_valid;
    logic        clr_start = 1'b0;
    logic [1:0]  clr_slot = '0;
    logic        clr_busy, clr_done, err;
    logic        err_clr = 1'b0;

    always #5 clk = ~clk;

    matrix_store #(.MAX_DIM(MD)) dut (
        .clk(clk), .rst(rst),
        .wr_slot(wr_slot), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .wr_we(wr_we),
        .dim_m(dim_m), .dim_n(dim_n), .dim_we(dim_we),
        .rd_slot(rd_slot), .rd_row(rd_row), .rd_col(rd_col), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_oob(rd_oob),
        .rd_dim_m(rd_dim_m), .rd_dim_n(rd_dim_n), .rd_slot_valid(rd_slot_valid),
        .clr_start(clr_start), .clr_slot(clr_slot), .clr_busy(clr_busy), .clr_done(clr_done),
        .err(err), .err_clr(err_clr)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: plain arrays per slot, clear modelled as a countdown of cells.
    int  m_mem   [4][MD][MD];
    bit  m_known [4][MD][MD];
    int  m_m [4];
    int  m_n [4];
    bit  m_valid [4];
    bit  m_err;
    int  phase;
    int  cidx;
    int  cslot;
    int  e_data;
    bit  e_known;
    bit  e_valid;
    bit  e_oob;

    task automatic model_edge();
        bit set_err;
        bit in_rng;
        if (rst) begin
            for (int s = 0; s < 4; s++) begin
                m_valid[s] = 0; m_m[s] = 0; m_n[s] = 0;
            end
            m_err = 0; phase = 0; e_data = 0; e_known = 1; e_valid = 0; e_oob = 0;
            return;
        end
        e_valid = rd_en;
        e_oob   = 0;
        if (rd_en) begin
            in_rng = m_valid[rd_slot] && (int'(rd_row) < m_m[rd_slot]) && (int'(rd_col) < m_n[rd_slot]);
            if (in_rng) begin
                e_data  = m_mem[rd_slot][rd_row][rd_col];
                e_known = m_known[rd_slot][rd_row][rd_col];
            end else begin
                e_data = 0; e_known = 1; e_oob = 1;
            end
        end
        set_err = 0;
        if (wr_we) begin
            if (phase == 0 && m_valid[wr_slot] && int'(wr_row) < m_m[wr_slot] && int'(wr_col) < m_n[wr_slot]) begin
                m_mem[wr_slot][wr_row][wr_col]   = int'(wr_data);
                m_known[wr_slot][wr_row][wr_col] = 1;
            end else begin
                set_err = 1;
            end
        end
        if (dim_we) begin
            if (phase == 0 && dim_m >= 1 && int'(dim_m) <= MD && dim_n >= 1 && int'(dim_n) <= MD) begin
                m_m[wr_slot] = int'(dim_m); m_n[wr_slot] = int'(dim_n); m_valid[wr_slot] = 1;
            end else begin
                set_err = 1;
            end
        end
        if (phase == 0) begin
            if (clr_start) begin
                cslot = int'(clr_slot);
                m_valid[cslot] = 0; m_m[cslot] = 0; m_n[cslot] = 0;
                cidx = 0; phase = 1;
            end
        end else if (phase == 1) begin
            m_mem[cslot][cidx / MD][cidx % MD]   = 0;
            m_known[cslot][cidx / MD][cidx % MD] = 1;
            cidx++;
            if (cidx == MD * MD) phase = 2;
        end else begin
            phase = 0;
        end
        if (set_err) m_err = 1;
        else if (err_clr) m_err = 0;
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; wr_we = 0; dim_we = 0; rd_en = 0; clr_start = 0; err_clr = 0;
    endtask

    task automatic do_dim(input int s, input int m, input int n);
        idle(); dim_we = 1; wr_slot = 2'(s); dim_m = 3'(m); dim_n = 3'(n);
        cyc(); dim_we = 0;
    endtask

    task automatic do_wr(input int s, input int r, input int c, input int d);
        idle(); wr_we = 1; wr_slot = 2'(s); wr_row = 3'(r); wr_col = 3'(c); wr_data = 16'(d);
        cyc(); wr_we = 0;
    endtask

    task automatic do_clr_err();
        idle(); err_clr = 1; cyc(); err_clr = 0;
    endtask

    task automatic test_reset();
        idle(); rst = 1; cyc(); cyc(); rst = 0;
        n_vec++;
        if ({rd_valid, rd_oob, clr_busy, clr_done, err} !== 5'b0) begin
            n_err++; $display("FAIL reset_flags: got %b expected 00000", {rd_valid, rd_oob, clr_busy, clr_done, err});
        end
        n_vec++;
        if (rd_data !== 16'h0000) begin
            n_err++; $display("FAIL reset_rd_data: got %h expected 0000", rd_data);
        end
        for (int s = 0; s < 4; s++) begin
            rd_slot = 2'(s); cyc();
            n_vec++;
            if ({rd_slot_valid, rd_dim_m, rd_dim_n} !== 7'b0) begin
                n_err++; $display("FAIL reset_slot%0d: got %b expected 0", s, {rd_slot_valid, rd_dim_m, rd_dim_n});
            end
        end
    endtask

    task automatic test_fill_read();
        rd_slot = 2'd2;
        do_dim(2, 3, 4);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                do_wr(2, r, c, r * 4 + c);
        n_vec++;
        if ({err, rd_slot_valid, rd_dim_m, rd_dim_n} !== {1'b0, 1'b1, 3'd3, 3'd4}) begin
            n_err++; $display("FAIL fill_state: got %b expected 0_1_011_100", {err, rd_slot_valid, rd_dim_m, rd_dim_n});
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                idle(); rd_en = 1; rd_slot = 2'd2; rd_row = 3'(r); rd_col = 3'(c);
                cyc();
                n_vec++;
                if ({rd_valid, rd_oob, rd_data} !== {1'b1, 1'b0, 16'(r * 4 + c)}) begin
                    n_err++; $display("FAIL fill_read(%0d,%0d): got v=%b o=%b d=%h expected v=1 o=0 d=%h",
                                      r, c, rd_valid, rd_oob, rd_data, 16'(r * 4 + c));
                end
            end
        end
        idle(); cyc();
        n_vec++;
        if ({rd_valid, rd_data} !== {1'b0, 16'd11}) begin
            n_err++; $display("FAIL read_hold: got v=%b d=%h expected v=0 d=000b", rd_valid, rd_data);
        end
    endtask

    task automatic test_errors();
        do_wr(1, 0, 0, 16'h00AA);
        n_vec++;
        if (err !== 1'b1) begin n_err++; $display("FAIL err_wr_invalid_slot: got %b expected 1", err); end
        do_clr_err();
        n_vec++;
        if (err !== 1'b0) begin n_err++; $display("FAIL err_clear: got %b expected 0", err); end
        do_wr(2, 3, 0, 16'h00BB);
        n_vec++;
        if (err !== 1'b1) begin n_err++; $display("FAIL err_wr_row_oob: got %b expected 1", err); end
        do_clr_err();
        rd_slot = 2'd3;
        do_dim(3, 0, 3);
        n_vec++;
        if ({err, rd_slot_valid} !== 2'b10) begin
            n_err++; $display("FAIL err_dim_zero: got %b expected 10", {err, rd_slot_valid});
        end
        do_clr_err();
        idle(); dim_we = 1; wr_slot = 2'd3; dim_m = 3'd6; dim_n = 3'd3; err_clr = 1;
        cyc(); idle();
        n_vec++;
        if ({err, rd_slot_valid} !== 2'b10) begin
            n_err++; $display("FAIL err_dim_six_over_clr: got %b expected 10", {err, rd_slot_valid});
        end
        do_clr_err();
        // Element write checks the old (invalid) dims even with dim_we alongside.
        rd_slot = 2'd1;
        idle(); dim_we = 1; wr_we = 1; wr_slot = 2'd1; dim_m = 3'd2; dim_n = 3'd2;
        wr_row = 3'd0; wr_col = 3'd0; wr_data = 16'h0CC0;
        cyc(); idle();
        n_vec++;
        if ({err, rd_slot_valid, rd_dim_m, rd_dim_n} !== {1'b1, 1'b1, 3'd2, 3'd2}) begin
            n_err++; $display("FAIL same_cycle_dim_wr: got %b expected 1_1_010_010", {err, rd_slot_valid, rd_dim_m, rd_dim_n});
        end
        do_clr_err();
    endtask

    task automatic test_oob();
        idle(); rd_en = 1; rd_slot = 2'd2; rd_row = 3'd3; rd_col = 3'd0;
        cyc(); idle();
        n_vec++;
        if ({rd_valid, rd_oob, err, rd_data} !== {3'b110, 16'h0000}) begin
            n_err++; $display("FAIL oob_row: got v=%b o=%b e=%b d=%h expected 1 1 0 0000", rd_valid, rd_oob, err, rd_data);
        end
        do_wr(0, 0, 0, 0);
        idle(); rd_en = 1; rd_slot = 2'd3; rd_row = 3'd0; rd_col = 3'd0;
        cyc(); idle();
        n_vec++;
        if ({rd_valid, rd_oob, err, rd_data} !== {3'b111, 16'h0000}) begin
            n_err++; $display("FAIL oob_slot: got v=%b o=%b e=%b d=%h expected 1 1 1 0000", rd_valid, rd_oob, err, rd_data);
        end
        do_clr_err();
    endtask

    task automatic test_rbw();
        do_wr(2, 1, 1, 16'h1234);
        idle(); wr_we = 1; wr_slot = 2'd2; wr_row = 3'd1; wr_col = 3'd1; wr_data = 16'h5678;
        rd_en = 1; rd_slot = 2'd2; rd_row = 3'd1; rd_col = 3'd1;
        cyc(); idle();
        n_vec++;
        if (rd_data !== 16'h1234) begin n_err++; $display("FAIL rbw_old: got %h expected 1234", rd_data); end
        rd_en = 1; cyc(); idle();
        n_vec++;
        if (rd_data !== 16'h5678) begin n_err++; $display("FAIL rbw_new: got %h expected 5678", rd_data); end
    endtask

    task automatic test_clear();
        int busy_cnt, done_cnt, busy_in_done;
        do_dim(0, 5, 5);
        for (int i = 0; i < MD * MD; i++) do_wr(0, i / MD, i % MD, 16'hFFFF);
        busy_cnt = 0; done_cnt = 0; busy_in_done = 0;
        for (int i = 0; i < 60 && done_cnt == 0; i++) begin
            idle(); rd_slot = 2'd0;
            if (i == 0) begin clr_start = 1; clr_slot = 2'd0; end
            if (i == 3) begin wr_we = 1; wr_slot = 2'd1; wr_row = 3'd0; wr_col = 3'd0; wr_data = 16'h7777; end
            if (i == 5) begin clr_start = 1; clr_slot = 2'd1; end
            cyc();
            if (clr_busy) busy_cnt++;
            if (clr_done) begin done_cnt++; if (clr_busy) busy_in_done++; end
        end
        idle(); cyc();
        n_vec++;
        if (busy_cnt != MD * MD) begin n_err++; $display("FAIL clr_busy_len: got %0d expected %0d", busy_cnt, MD * MD); end
        n_vec++;
        if (done_cnt != 1 || busy_in_done != 0 || clr_done !== 1'b0) begin
            n_err++; $display("FAIL clr_done_pulse: got cnt=%0d busy_in_done=%0d after=%b expected 1 0 0",
                              done_cnt, busy_in_done, clr_done);
        end
        n_vec++;
        if ({rd_slot_valid, err} !== 2'b01) begin
            n_err++; $display("FAIL clr_slot_state: got valid=%b err=%b expected 0 1", rd_slot_valid, err);
        end
        rd_slot = 2'd1; #1;
        n_vec++;
        if (rd_slot_valid !== 1'b1) begin n_err++; $display("FAIL clr_ignored_start: got %b expected 1", rd_slot_valid); end
        do_clr_err();
        do_dim(0, 5, 5);
        for (int i = 0; i < MD * MD; i++) begin
            idle(); rd_en = 1; rd_slot = 2'd0; rd_row = 3'(i / MD); rd_col = 3'(i % MD);
            cyc();
            n_vec++;
            if ({rd_oob, rd_data} !== 17'h0) begin
                n_err++; $display("FAIL clr_zero cell %0d: got o=%b d=%h expected 0 0000", i, rd_oob, rd_data);
            end
        end
        idle();
    endtask

    task automatic test_rst_mid_clear();
        int busy_cnt, done_cnt;
        do_wr(0, 4, 4, 0);
        do_wr(3, 0, 0, 0);
        idle(); rd_en = 1; rd_slot = 2'd2; rd_row = 3'd1; rd_col = 3'd1; cyc();
        idle(); clr_start = 1; clr_slot = 2'd0; cyc();
        busy_cnt = clr_busy ? 1 : 0; done_cnt = 0;
        for (int i = 0; i < 30 && busy_cnt < 10; i++) begin
            idle(); cyc();
            if (clr_busy) busy_cnt++;
        end
        idle(); rst = 1; cyc(); rst = 0;
        n_vec++;
        if ({rd_valid, rd_oob, clr_busy, clr_done, err, rd_data} !== 21'h0) begin
            n_err++; $display("FAIL rst_mid_clear_outputs: got %b %h expected 0 0000",
                              {rd_valid, rd_oob, clr_busy, clr_done, err}, rd_data);
        end
        for (int s = 0; s < 4; s++) begin
            rd_slot = 2'(s); cyc();
            if (clr_done) done_cnt++;
            n_vec++;
            if ({rd_slot_valid, rd_dim_m, rd_dim_n} !== 7'b0) begin
                n_err++; $display("FAIL rst_mid_clear_slot%0d: got %b expected 0", s, {rd_slot_valid, rd_dim_m, rd_dim_n});
            end
        end
        for (int i = 0; i < 20; i++) begin cyc(); if (clr_done) done_cnt++; end
        n_vec++;
        if (done_cnt != 0) begin n_err++; $display("FAIL rst_aborts_done: got %0d pulses expected 0", done_cnt); end
        busy_cnt = 0;
        for (int i = 0; i < 60 && done_cnt == 0; i++) begin
            idle();
            if (i == 0) begin clr_start = 1; clr_slot = 2'd1; end
            cyc();
            if (clr_busy) busy_cnt++;
            if (clr_done) done_cnt++;
        end
        idle();
        n_vec++;
        if (busy_cnt != MD * MD || done_cnt != 1) begin
            n_err++; $display("FAIL clear_after_rst: got busy=%0d done=%0d expected %0d 1", busy_cnt, done_cnt, MD * MD);
        end
        cyc();
    endtask

    task automatic test_random();
        logic [10:0] got, exp_v;
        for (int i = 0; i < 600; i++) begin
            rst       = 0;
            wr_we     = 1'($urandom_range(0, 1));
            wr_slot   = 2'($urandom_range(0, 3));
            wr_row    = 3'($urandom_range(0, 6));
            wr_col    = 3'($urandom_range(0, 6));
            wr_data   = 16'($urandom);
            dim_we    = ($urandom_range(0, 7) == 0);
            dim_m     = 3'($urandom_range(0, 7));
            dim_n     = 3'($urandom_range(0, 7));
            rd_en     = 1'($urandom_range(0, 1));
            rd_slot   = 2'($urandom_range(0, 3));
            rd_row    = 3'($urandom_range(0, 6));
            rd_col    = 3'($urandom_range(0, 6));
            clr_start = ($urandom_range(0, 59) == 0);
            clr_slot  = 2'($urandom_range(0, 3));
            err_clr   = ($urandom_range(0, 5) == 0);
            cyc();
            got   = {rd_valid, rd_oob, clr_busy, clr_done, err, rd_slot_valid, rd_dim_m, rd_dim_n};
            exp_v = {e_valid, e_oob, phase == 1, phase == 2, m_err, m_valid[rd_slot],
                     3'(m_m[rd_slot]), 3'(m_n[rd_slot])};
            n_vec++;
            if (got !== exp_v) begin
                n_err++; $display("FAIL random_ctrl cycle %0d: got %b expected %b", i, got, exp_v);
            end
            if (e_known) begin
                n_vec++;
                if (rd_data !== 16'(e_data)) begin
                    n_err++; $display("FAIL random_data cycle %0d: got %h expected %h", i, rd_data, 16'(e_data));
                end
            end
        end
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        test_reset();
        test_fill_read();
        test_errors();
        test_oob();
        test_rbw();
        test_clear();
        test_rst_mid_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/matrix_store.md
# matrix_store

Slot-organised matrix storage directly downstream of the random-matrix generator and the manual-entry path. Holds up to four matrices of at most MAX_DIM×MAX_DIM 16-bit elements, each with its own dimension registers and valid flag. Accepts element and dimension writes in the generator's port format. Provides a registered element read port for the compute and display stages, and contains a sequential slot-clear engine.

## Interface

Parameters:
- MAX_DIM, 5, largest legal row and column count. Legal range 1..7.

Ports (clk and rst first):
- clk  in  1  single system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- wr_slot  in  2  slot for element and dimension writes
- wr_row, wr_col  in  3 each  element coordinates
- wr_data  in  16  element value
- wr_we  in  1  element write strobe
- dim_m, dim_n  in  3 each  dimensions to store
- dim_we  in  1  dimension write strobe; applies to wr_slot
- rd_slot  in  2  read slot
- rd_row, rd_col  in  3 each  read coordinates
- rd_en  in  1  read request
- rd_data  out  16  read result, registered
- rd_valid  out  1  one-cycle pulse, qualifies rd_data
- rd_oob  out  1  read was out of range; same cycle as rd_valid
- rd_dim_m, rd_dim_n  out  3 each  dimensions of rd_slot; combinational from registers
- rd_slot_valid  out  1  rd_slot holds valid dimensions; combinational
- clr_start  in  1  request to clear a slot
- clr_slot  in  2  slot to clear
- clr_busy  out  1  clear engine running
- clr_done  out  1  one-cycle pulse when a clear completes
- err  out  1  sticky error flag
- err_clr  in  1  clears err

## Operation

- Reset (rst high at an edge) gives the following state:
  - all slot valid flags 0; all dims 0
  - rd_data 0; rd_valid, rd_oob, clr_busy, clr_done, err all 0
  - clear FSM in C_IDLE
  - element memory is not reset; only a clear zeroes it
  - rst asserted mid-clear aborts the clear with no clr_done
- Dimension write, when dim_we is sampled:
  - accepted if 1≤dim_m≤MAX_DIM and 1≤dim_n≤MAX_DIM and the clear FSM is in C_IDLE
  - accepted: stores the dims and sets the slot valid flag
  - otherwise: dropped, err set
- Element write, when wr_we is sampled:
  - accepted if the slot is valid, wr_row<slot m, wr_col<slot n, and the FSM is in C_IDLE
  - otherwise: dropped, err set
  - validity uses register values before the edge, so dim_we and wr_we in the same cycle check the old dims
- Read, when rd_en is sampled:
  - in range (slot valid, row<m, col<n): rd_data = stored element, rd_oob=0
  - otherwise: rd_data=0, rd_oob=1; err is not touched
  - read of a cell written in the same cycle returns the old value (read-before-write)
  - reads are always allowed, including during a clear
- Clear FSM, states C_IDLE → C_RUN → C_DONE → C_IDLE:
  - C_IDLE: clr_start latches clr_slot, zeroes that slot's dims and valid flag, resets the (r,c) counters to (0,0), goes to C_RUN
  - C_RUN: writes 0 to (r,c), one cell per cycle, c fastest, covering MAX_DIM×MAX_DIM cells; the last cell goes to C_DONE
  - C_DONE: one cycle, then C_IDLE
  - clr_start outside C_IDLE is ignored, with no error
- err: sticky. A set event wins over err_clr in the same cycle.
- Storage is 4×MAX_DIM×MAX_DIM words, addressed slot·MAX_DIM² + row·MAX_DIM + col.
- An element write accepted in the same cycle that clr_start is sampled is performed, then wiped by the clear.

## Timing

- Read latency 1: rd_en sampled at edge T gives rd_data, rd_valid and rd_oob valid after edge T, for one cycle only. rd_valid=0 otherwise; rd_data holds its last value.
- Writes take effect at the sampling edge; a read issued in the following cycle sees the new value.
- Clear with clr_start sampled at edge T:
  - clr_busy=1 for cycles T+1 through T+MAX_DIM²
  - clr_done=1 for exactly one cycle, after edge T+MAX_DIM², with clr_busy=0 in that cycle
  - next clr_start is accepted one cycle later (C_DONE→C_IDLE)
  - MAX_DIM=5: busy for 25 cycles; done in cycle 26
- A generator burst for an m×n matrix (one dim write, then m·n consecutive element writes) is absorbed with no stalls.

## Test plan

- Dim write slot 2 as 3×4, then 12 writes with data=row*4+col; read all 12 → each rd_data matches, rd_valid one cycle each, rd_oob=0, err=0.
- Element write to slot 1 before any dim write, then slot 2 (3×4) at row=3 → both dropped, err=1. err_clr → err=0. dim_we with dim_m=0, and separately with dim_m=6 → err=1 each time.
- Read slot 2 (3,0), and read invalid slot 3 → rd_data=0, rd_oob=1, err unchanged.
- Fill slot 0 as 5×5 with 16'hFFFF; clr_start on slot 0 → clr_busy high exactly 25 cycles, clr_done single pulse, rd_slot_valid=0. Re-dim 5×5, read all 25 → 0. wr_we issued during busy → dropped, err=1.
- Write 16'h1234 then 16'h5678 to one cell, with the second write and rd_en in the same cycle → 16'h1234 returned; next read → 16'h5678.
- Assert rst at busy cycle 10 of a clear → no clr_done; all flags, dims and outputs at reset values; a new clear then runs a full 25 cycles.
